// File: rtl/rr_mux_reg_pkg.sv
// Shared constants and helpers for the round-robin mux register and its arbiter.
package rr_mux_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Channel-index width; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_reg_arbiter.sv
// Request arbiter: round-robin from a rotating pointer, or fixed priority with channel 0 highest.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  ARB_MODE = ARB_RR,
    localparam int CH_W     = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              advance_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [CH_W-1:0]   grant_idx_o
);

    logic [CH_W-1:0] rr_ptr_q;
    logic [CH_W-1:0] rr_ptr_d;

    always_comb begin
        logic [CH_W-1:0] idx;
        logic            found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == ARB_FIXED) begin
                idx = CH_W'(k);
            end else begin
                idx = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            end
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o = idx;
            end
        end
    end

    // Pointer moves past the winner only when its word is actually taken.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance_i) begin
            rr_ptr_d = (grant_idx_o == CH_W'(NUM_CH - 1)) ? '0 : grant_idx_o + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel valid/ready arbiter feeding one registered output stage.
// Optional 1-entry skid buffer behind the output register: define RR_MUX_REG_SKID_EN.
module rr_mux_reg
    import rr_mux_pkg::*;
#(
    parameter int  WIDTH    = 16,
    parameter int  NUM_CH   = 4,
    parameter int  ARB_MODE = ARB_RR,
    localparam int CH_W     = ch_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       in_valid_i,
    input  logic [NUM_CH*WIDTH-1:0] in_data_i,
    output logic [NUM_CH-1:0]       in_ready_o,
    output logic                    out_valid_o,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [CH_W-1:0]         out_ch_o,
    input  logic                    out_ready_i
);

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              load;
    logic              xfer_in;
    logic [WIDTH-1:0]  ch_data [NUM_CH];
    logic [WIDTH-1:0]  sel_data;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [CH_W-1:0]   out_ch_q,    out_ch_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data_i[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (in_valid_i),
        .advance_i   (xfer_in),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign sel_data   = ch_data[grant_idx];
    assign in_ready_o = grant & {NUM_CH{load}};
    assign xfer_in    = |grant & load;

`ifdef RR_MUX_REG_SKID_EN
    logic              skid_full_q, skid_full_d;
    logic [WIDTH-1:0]  skid_data_q, skid_data_d;
    logic [CH_W-1:0]   skid_ch_q,   skid_ch_d;

    // Acceptance depends only on local state, so out_ready never reaches in_ready.
    assign load = ~skid_full_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_ch_d   = skid_ch_q;
        if (~out_valid_q | out_ready_i) begin
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                out_data_d  = skid_data_q;
                out_ch_d    = skid_ch_q;
                skid_full_d = 1'b0;
            end else if (xfer_in) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_ch_d    = grant_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (xfer_in) begin
            skid_full_d = 1'b1;
            skid_data_d = sel_data;
            skid_ch_d   = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_ch_q   <= '0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_ch_q   <= skid_ch_d;
        end
    end
`else
    assign load = ~out_valid_q | out_ready_i;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (xfer_in) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = grant_idx;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
Parametrised N-channel successor to the team's 16-bit register and 2:1 mux pair. It arbitrates NUM_CH valid/ready input streams of WIDTH bits and registers the winner into a single output stage with a valid/ready handshake. Arbitration is round-robin or fixed-priority. It sits between producer engines and any shared downstream datapath consumer.

Parameters:
WIDTH, 16, data width per channel
NUM_CH, 4, number of input channels (2..16)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)
CH_W, $clog2(NUM_CH), localparam, channel-index width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
in_valid  in  NUM_CH  per-channel request
in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_ready  out  NUM_CH  per-channel accept; one-hot or zero
out_valid  out  1  output register holds a word
out_data  out  WIDTH  registered winning word
out_ch  out  CH_W  source channel of out_data
out_ready  in  1  downstream accept

Behaviour:
- Clock clk; reset is synchronous, active-high. Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=0, skid empty.
- Grant logic (combinational):
  - ARB_MODE=0: the first requesting channel searching from rr_ptr upward, with wrap at NUM_CH-1 -> 0.
  - ARB_MODE=1: the lowest-index requesting channel.
- load = ~out_valid | out_ready.
- in_ready[i] = grant[i] & load. At most one bit is set. in_ready is zero when no in_valid bit is set.
- Transfer on a channel occurs when in_valid[i] & in_ready[i]. The output register captures in_data[i] and i, and out_valid=1 on the next edge. Latency is 1 cycle from accept to out_valid.
- Output transfer occurs when out_valid & out_ready. If there is no simultaneous input transfer, out_valid clears next edge.
- Simultaneous output and input transfer in the same cycle: the register reloads and out_valid stays 1. This gives full throughput of 1 word/cycle.
- Stall (out_valid & ~out_ready): out_data and out_ch hold stable, and in_ready is all zero.
- rr_ptr updates only on an input transfer, to (granted+1) mod NUM_CH. It is unused when ARB_MODE=1.
- in_data is don't-care where in_valid=0. out_data retains its last value when out_valid=0.
- Reset asserted mid-operation discards the held word and returns rr_ptr to 0 at the same edge.

Optional Feature:
RR_MUX_REG_SKID_EN
- Defined: adds a 1-entry skid buffer behind the output register. load becomes ~skid_full, with no combinational path from out_ready to in_ready.
  - An input transfer during an output stall goes to the skid buffer.
  - When the output frees, the skid entry moves to the output register first.
  - Capacity is 2 words. Accept-to-out_valid latency stays 1 cycle when the output register is empty.
  - Ordering is preserved.
- Undefined: no skid buffer; behaviour exactly as above, capacity 1.

Decomposition:
- Package rr_mux_pkg holds:
  - ARB_RR=0 and ARB_FIXED=1 constants
  - a function computing the channel-index width.
- Sub-module rr_arbiter (parameters NUM_CH, ARB_MODE) contains:
  - inputs: req, advance
  - outputs: one-hot grant, binary grant index
  - the rr_ptr register
- rr_mux_reg instantiates rr_arbiter once and owns the output register and skid logic.

Test Plan:
- Reset then idle: all in_valid=0 -> out_valid=0, in_ready=0, out_data=0x0000, out_ch=0.
- Single channel: ch2 valid with data 0xBEEF, out_ready=1 -> in_ready=4'b0100. The next cycle shows out_valid=1, out_data=0xBEEF, out_ch=2.
- Round-robin fairness: NUM_CH=4, all channels valid continuously, out_ready=1 -> grant order 0,1,2,3,0,… with one word per cycle and no bubbles.
- Fixed priority: ARB_MODE=1, channels 1 and 3 valid -> ch1 is always granted and ch3 is starved while ch1 stays valid.
- Back-pressure: out_ready=0 for 3 cycles with a word 0x1234 held -> output stays 0x1234 and in_ready=0. With RR_MUX_REG_SKID_EN defined, exactly one extra word is accepted and emitted next, in order, after out_ready=1.
- Reset mid-stall: out_valid=1 held, reset pulsed -> out_valid=0 next edge, and the next grant with all channels valid is ch0.
